viterbi_traceback: RTL
======================

Name: viterbi_traceback

Overview:
Survivor-memory and traceback stage, directly downstream of the per-state add-compare-select units of the Viterbi decoder. Each trellis step, it captures the column of per-state selection bits into a frame buffer. At end of frame it traces back from state 0 (the encoder is tail-terminated). It then emits the decoded message bits in forward time order over a valid/ready handshake.

Parameters:
STATE_W, 3, encoder memory bits; states = 2**STATE_W (8).
MAX_LEN, 64, maximum trellis steps per frame, including tail.
TAIL, STATE_W, tail steps stripped from the output.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
surv_valid  in  1  survivor column present this cycle
surv_ready  out  1  block accepts a column (high only in FILL)
surv_bits  in  2**STATE_W  bit s = ACS selection for state s (1 = predecessor with LSB 1)
surv_last  in  1  qualifies the final column of the frame
dec_valid  out  1  decoded bit available
dec_ready  in  1  consumer accepts dec_bit
dec_bit  out  1  decoded message bit
dec_last  out  1  marks the final decoded bit of the frame
frame_err  out  1  one-cycle pulse: frame too short, or MAX_LEN overflow
busy  out  1  high in TRACE or EMIT

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: FSM=FILL, wr_ptr=0, surv_ready=1, dec_valid=0, dec_bit=0, dec_last=0, frame_err=0, busy=0. The survivor array and bit buffer are not reset.
- Trellis convention:
  - next state = {in_bit, s[STATE_W-1:1]}.
  - Predecessor of s given selection sel = {s[STATE_W-2:0], sel}.
  - Decoded bit of step t = MSB of the state after step t.
- FILL:
  - A column is accepted when surv_valid & surv_ready. It is written at wr_ptr, and wr_ptr increments.
  - On acceptance with surv_last=1, or when the accepted column is at wr_ptr==MAX_LEN-1: len = wr_ptr+1; go to TRACE next cycle.
  - MAX_LEN overflow without surv_last: frame_err pulses the cycle after, and the frame is still traced.
- TRACE:
  - Start values: cur=0, t=len-1.
  - Each cycle: bitbuf[t] = cur[STATE_W-1]; sel = mem[t][cur]; cur = {cur[STATE_W-2:0], sel}; t--.
  - Takes exactly len cycles (combinational read of the column, one step per cycle). After step t=0, go to EMIT.
  - If len <= TAIL: no bits are emitted; frame_err pulses; return to FILL with wr_ptr=0.
- EMIT:
  - Output index r runs 0..len-TAIL-1. dec_bit=bitbuf[r] and dec_valid=1 are registered.
  - r advances on dec_valid & dec_ready. dec_last=1 when r==len-TAIL-1.
  - After the last handshake: dec_valid=0 next cycle, FILL with wr_ptr=0, surv_ready=1.
  - dec_bit/dec_last are held stable while dec_valid & !dec_ready.
- Latency: first dec_valid appears len+1 cycles after the cycle accepting the last column.
- Backpressure: surv_ready=0 throughout TRACE/EMIT; columns presented then are not captured.
- Simultaneous events: surv_last on the MAX_LEN-1 column is a normal end (no frame_err).
- rst_n assertion mid-TRACE/EMIT aborts the frame immediately to reset values. No partial output follows.
- Widths: wr_ptr, t, r and len are $clog2(MAX_LEN+1) bits. The survivor column is 2**STATE_W bits.

Decomposition:
- viterbi_pkg holds:
  - constants STATE_W, NUM_STATES;
  - typedef state_t (logic [STATE_W-1:0]);
  - typedef surv_col_t (logic [NUM_STATES-1:0]);
  - enum tb_state_e {FILL, TRACE, EMIT}.
- Sub-module survivor_mem: MAX_LEN x NUM_STATES register array, one synchronous write port, one combinational read port returning the column at index t.
- FSM, pointers and the bit buffer live in viterbi_traceback.

Test Plan:
- Known path: len=8 frame with surv_last on column 7. Every survivor bit is 1 except col0[4], col1[2], col2[5], col4[3], col7[0]=0. Expected:
  - TRACE lasts 8 cycles;
  - outputs 1,0,1,1,0, with dec_last on the 5th;
  - surv_ready returns high.
- All-zero survivors, len=10 -> 7 zero bits, no frame_err.
- Backpressure: known-path frame with dec_ready toggling 1,0,0,1,... -> same 5 bits, each held stable while stalled, none dropped or duplicated.
- Short frame: len=3 (surv_last on column 2) -> frame_err pulse, no dec_valid, back to FILL.
- Overflow: 64 columns with surv_last=0 -> frame_err pulse, traced as len=64, 61 bits emitted.
- Reset mid-EMIT, after 2 bits -> outputs cleared asynchronously. A following len=8 known-path frame decodes correctly.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi traceback stage.
// The trellis helper encodes the predecessor rule used during traceback.
package viterbi_pkg;

    localparam int STATE_W    = 3;
    localparam int NUM_STATES = 1 << STATE_W;

    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [NUM_STATES-1:0] surv_col_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        EMIT  = 2'd2
    } tb_state_e;

    // Shift the selection bit in at the LSB: the state one step earlier in time.
    function automatic state_t predecessor(input state_t s, input logic sel);
        return {s[STATE_W-2:0], sel};
    endfunction

endpackage

// File: rtl/viterbi_traceback_if.sv
// Survivor-column input stream and decoded-bit output stream of the traceback stage.
// The slave modport is the traceback block; master is the surrounding decoder/consumer.
interface viterbi_traceback_if;
    import viterbi_pkg::*;

    logic      surv_valid;
    logic      surv_ready;
    surv_col_t surv_bits;
    logic      surv_last;

    logic      dec_valid;
    logic      dec_ready;
    logic      dec_bit;
    logic      dec_last;

    modport master (
        output surv_valid, surv_bits, surv_last, dec_ready,
        input  surv_ready, dec_valid, dec_bit, dec_last
    );

    modport slave (
        input  surv_valid, surv_bits, surv_last, dec_ready,
        output surv_ready, dec_valid, dec_bit, dec_last
    );

endinterface

// File: rtl/survivor_mem.sv
// Frame buffer of ACS selection columns: one synchronous write port and one
// combinational read port so traceback can advance one trellis step per cycle.
module survivor_mem
    import viterbi_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  surv_col_t         wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output surv_col_t         rdata_o
);

    surv_col_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor capture, traceback from state 0 and forward-order emission of decoded bits.
// The tail-terminated frame is walked backwards once, then replayed from the bit buffer.
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int TAIL    = STATE_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    viterbi_traceback_if.slave  bus,
    output logic                frame_err_o,
    output logic                busy_o
);

    localparam int PTR_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LEN - 1);
    localparam logic [PTR_W-1:0] TAIL_LEN = PTR_W'(TAIL);
    localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

    tb_state_e        state_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] len_q;
    logic [PTR_W-1:0] t_q;
    logic [PTR_W-1:0] r_q;
    state_t           cur_q;
    logic             survReady_q;
    logic             decValid_q;
    logic             decBit_q;
    logic             decLast_q;
    logic             frameErr_q;
    logic             busy_q;

    logic [MAX_LEN-1:0] bitBuf_q;

    logic             colAccept;
    logic             colSel;
    state_t           curNext;
    logic [PTR_W-1:0] lastIdx;
    logic [PTR_W-1:0] rNext;
    surv_col_t        rdCol;

    assign colAccept = bus.surv_valid & survReady_q;
    assign colSel    = rdCol[cur_q];
    assign curNext   = predecessor(cur_q, colSel);
    assign lastIdx   = len_q - TAIL_LEN - ONE;
    assign rNext     = r_q + ONE;

    survivor_mem #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (colAccept),
        .waddr_i (wrPtr_q[ADDR_W-1:0]),
        .wdata_i (bus.surv_bits),
        .raddr_i (t_q[ADDR_W-1:0]),
        .rdata_o (rdCol)
    );

    // Bit buffer is plain storage: every entry read in EMIT was written during TRACE.
    always_ff @(posedge clk_i) begin
        if (state_q == TRACE) begin
            bitBuf_q[t_q[ADDR_W-1:0]] <= cur_q[STATE_W-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            wrPtr_q     <= '0;
            len_q       <= '0;
            t_q         <= '0;
            r_q         <= '0;
            cur_q       <= '0;
            survReady_q <= 1'b1;
            decValid_q  <= 1'b0;
            decBit_q    <= 1'b0;
            decLast_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (colAccept) begin
                        wrPtr_q <= wrPtr_q + ONE;
                        if (bus.surv_last || (wrPtr_q == LAST_PTR)) begin
                            len_q       <= wrPtr_q + ONE;
                            t_q         <= wrPtr_q;
                            cur_q       <= '0;
                            survReady_q <= 1'b0;
                            busy_q      <= 1'b1;
                            frameErr_q  <= ~bus.surv_last;
                            state_q     <= TRACE;
                        end
                    end
                end

                TRACE: begin
                    cur_q <= curNext;
                    t_q   <= t_q - ONE;
                    if (t_q == '0) begin
                        if (len_q <= TAIL_LEN) begin
                            frameErr_q  <= 1'b1;
                            wrPtr_q     <= '0;
                            survReady_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= FILL;
                        end else begin
                            // Step 0's bit lands in the buffer this same edge, so forward it.
                            r_q        <= '0;
                            decValid_q <= 1'b1;
                            decBit_q   <= cur_q[STATE_W-1];
                            decLast_q  <= (lastIdx == '0);
                            state_q    <= EMIT;
                        end
                    end
                end

                EMIT: begin
                    if (decValid_q && bus.dec_ready) begin
                        if (r_q == lastIdx) begin
                            decValid_q  <= 1'b0;
                            decLast_q   <= 1'b0;
                            wrPtr_q     <= '0;
                            survReady_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= FILL;
                        end else begin
                            r_q       <= rNext;
                            decBit_q  <= bitBuf_q[rNext[ADDR_W-1:0]];
                            decLast_q <= (rNext == lastIdx);
                        end
                    end
                end

                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign bus.surv_ready = survReady_q;
    assign bus.dec_valid  = decValid_q;
    assign bus.dec_bit    = decBit_q;
    assign bus.dec_last   = decLast_q;
    assign frame_err_o    = frameErr_q;
    assign busy_o         = busy_q;

endmodule
